// File: rtl/ctrl_rx_frame.sv
// RS-485 control-link receiver: UART deserialiser plus command-frame parser driving fx write/read strobes.
// Latency: stop-bit sample to internal byte 1 cycle, SUM byte to fx strobe 1 cycle, fx_rd to rd_vld 2 cycles; no backpressure.
module ctrl_rx_frame #(
  parameter int CLK_DIV    = 434,
  parameter int TIMEOUT_US = 1000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pluse_us,
  input  logic        rx_ctrl,
  input  logic [7:0]  dev_id,
  output logic [15:0] fx_waddr,
  output logic        fx_wr,
  output logic [7:0]  fx_data,
  output logic [15:0] fx_raddr,
  output logic        fx_rd,
  input  logic [7:0]  fx_q,
  output logic        rd_vld,
  output logic [7:0]  rd_data,
  output logic        err_sum,
  output logic        err_frm,
  output logic        err_tmo
);

  localparam logic [15:0] DIV_FULL = 16'(CLK_DIV - 1);
  localparam logic [15:0] DIV_HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] TMO      = 16'(TIMEOUT_US);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
  typedef enum logic [2:0] {P_IDLE, P_DEV, P_CMD, P_AH, P_AL, P_DAT, P_SUM, P_EXEC} pstate_t;

  ustate_t     ust;
  logic        rx_m, rx_s, rx_d;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        byte_vld;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      ust      <= U_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_vld <= 1'b0;
      err_frm  <= 1'b0;
    end else begin
      rx_m     <= rx_ctrl;
      rx_s     <= rx_m;
      rx_d     <= rx_s;
      byte_vld <= 1'b0;
      err_frm  <= 1'b0;
      case (ust)
        U_IDLE: if (rx_d && !rx_s) begin
          ust     <= U_START;
          bit_cnt <= '0;
        end
        U_START: if (bit_cnt == DIV_HALF) begin
          bit_cnt <= '0;
          bit_idx <= '0;
          // A high line at mid-start is a glitch, not a byte.
          ust     <= rx_s ? U_IDLE : U_DATA;
        end else begin
          bit_cnt <= bit_cnt + 16'd1;
        end
        U_DATA: if (bit_cnt == DIV_FULL) begin
          bit_cnt <= '0;
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) ust <= U_STOP;
        end else begin
          bit_cnt <= bit_cnt + 16'd1;
        end
        U_STOP: if (bit_cnt == DIV_FULL) begin
          bit_cnt <= '0;
          ust     <= U_IDLE;
          if (rx_s) byte_vld <= 1'b1;
          else      err_frm  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 16'd1;
        end
      endcase
    end
  end

  pstate_t     pst;
  logic        wr, dev_hit, dev_bc, rd_pend;
  logic [7:0]  ah, al, dat, sum;
  logic [15:0] tmo_cnt;
  logic        mine;

  // Broadcast only qualifies writes, and wr is known only after CMD.
  assign mine = dev_hit || (dev_bc && wr);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pst      <= P_IDLE;
      wr       <= 1'b0;
      dev_hit  <= 1'b0;
      dev_bc   <= 1'b0;
      ah       <= '0;
      al       <= '0;
      dat      <= '0;
      sum      <= '0;
      tmo_cnt  <= '0;
      rd_pend  <= 1'b0;
      fx_waddr <= '0;
      fx_wr    <= 1'b0;
      fx_data  <= '0;
      fx_raddr <= '0;
      fx_rd    <= 1'b0;
      rd_vld   <= 1'b0;
      rd_data  <= '0;
      err_sum  <= 1'b0;
      err_tmo  <= 1'b0;
    end else begin
      fx_wr   <= 1'b0;
      fx_rd   <= 1'b0;
      err_sum <= 1'b0;
      err_tmo <= 1'b0;
      rd_pend <= fx_rd;
      rd_vld  <= rd_pend;
      if (rd_pend) rd_data <= fx_q;

      if (byte_vld || pst == P_IDLE) tmo_cnt <= '0;
      else if (pluse_us && tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;

      if (err_frm) begin
        pst <= P_IDLE;
      end else if (byte_vld) begin
        sum <= sum + shreg;
        case (pst)
          P_IDLE: if (shreg == 8'hA5) begin
            pst <= P_DEV;
            sum <= '0;
          end
          P_DEV: begin
            dev_hit <= (shreg == dev_id);
            dev_bc  <= (shreg == 8'hFF);
            pst     <= P_CMD;
          end
          P_CMD: begin
            if (shreg == 8'h01) begin
              wr  <= 1'b1;
              pst <= P_AH;
            end else if (shreg == 8'h02) begin
              wr  <= 1'b0;
              pst <= P_AH;
            end else begin
              pst <= P_IDLE;
            end
          end
          P_AH: begin
            ah  <= shreg;
            pst <= P_AL;
          end
          P_AL: begin
            al  <= shreg;
            pst <= wr ? P_DAT : P_SUM;
          end
          P_DAT: begin
            dat <= shreg;
            pst <= P_SUM;
          end
          P_SUM: begin
            if (shreg != sum) begin
              err_sum <= 1'b1;
              pst     <= P_IDLE;
            end else if (mine) begin
              pst <= P_EXEC;
              if (wr) begin
                fx_wr    <= 1'b1;
                fx_waddr <= {ah, al};
                fx_data  <= dat;
              end else begin
                fx_rd    <= 1'b1;
                fx_raddr <= {ah, al};
              end
            end else begin
              pst <= P_IDLE;
            end
          end
          P_EXEC: pst <= P_IDLE;
        endcase
      end else if (pst == P_EXEC) begin
        pst <= P_IDLE;
      end else if (pst != P_IDLE && tmo_cnt >= TMO) begin
        err_tmo <= 1'b1;
        pst     <= P_IDLE;
      end
    end
  end

endmodule
